// File: rtl/usb1bd_pkg.sv
// Shared types and handshake codes for the USB 1.1 device transaction sequencer.
package usb1bd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRxData,
    StTxHs,
    StTxData,
    StWaitAck
  } state_e;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b01;
  localparam logic [1:0] HS_STALL = 2'b10;

  // Endpoint vectors are widened to the full 4-bit endpoint space before indexing.
  localparam int unsigned EpSpace = 16;

endpackage

// File: rtl/usb1bd_txn_ctrl_if.sv
// Event/request bundle between the packet disassembler/assembler and the transaction sequencer.
interface usb1bd_txn_ctrl_if;

  logic       token_valid;
  logic [6:0] token_fadr;
  logic [3:0] token_endp;
  logic       pid_OUT;
  logic       pid_IN;
  logic       pid_SETUP;
  logic       pid_SOF;
  logic       pid_ACK;
  logic       pid_DATA0;
  logic       pid_DATA1;
  logic       pid_cks_err;
  logic       crc5_err;
  logic       crc16_err;
  logic       rx_data_done;
  logic       tx_done;

  logic [3:0] ep_sel;
  logic       send_hs;
  logic [1:0] hs_code;
  logic       send_data;
  logic       data_pid1;
  logic       ep_in_commit;
  logic       ep_out_commit;
  logic       ep_out_discard;
  logic       sof_pulse;

  modport master (
    output token_valid, token_fadr, token_endp,
    output pid_OUT, pid_IN, pid_SETUP, pid_SOF, pid_ACK, pid_DATA0, pid_DATA1,
    output pid_cks_err, crc5_err, crc16_err, rx_data_done, tx_done,
    input  ep_sel, send_hs, hs_code, send_data, data_pid1,
    input  ep_in_commit, ep_out_commit, ep_out_discard, sof_pulse
  );

  modport slave (
    input  token_valid, token_fadr, token_endp,
    input  pid_OUT, pid_IN, pid_SETUP, pid_SOF, pid_ACK, pid_DATA0, pid_DATA1,
    input  pid_cks_err, crc5_err, crc16_err, rx_data_done, tx_done,
    output ep_sel, send_hs, hs_code, send_data, data_pid1,
    output ep_in_commit, ep_out_commit, ep_out_discard, sof_pulse
  );

endinterface

// File: rtl/usb1bd_tmo_cnt.sv
// Loadable down-counter; 'expired' is high in the cycle the enabled count reads 1,
// i.e. exactly TMO_CYC enabled cycles after a load.
module usb1bd_tmo_cnt #(
  parameter int unsigned TMO_CYC = 96
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TMO_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(TMO_CYC);
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == CntW'(1));

endmodule

// File: rtl/usb1bd_txn_ctrl.sv
// Device-side USB 1.1 transaction sequencer: token decode, handshake choice,
// per-endpoint DATA0/DATA1 toggles, host response timeouts and buffer commit/discard.
module usb1bd_txn_ctrl
  import usb1bd_pkg::*;
#(
  parameter int unsigned NUM_EP  = 4,
  parameter int unsigned TMO_CYC = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        cfg_fadr,
  input  logic [NUM_EP-1:0] ep_en,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] ep_in_rdy,
  input  logic [NUM_EP-1:0] ep_out_space,
  input  logic [NUM_EP-1:0] ep_tgl_clr,
  output logic [NUM_EP-1:0] ep_tgl,
  usb1bd_txn_ctrl_if.slave  bus
);

  state_e state_q, state_d;

  logic [3:0]        ep_sel_q, ep_sel_d;
  logic              setup_q, setup_d;
  logic              space_q, space_d;
  logic              send_hs_q, send_hs_d;
  logic [1:0]        hs_code_q, hs_code_d;
  logic              send_data_q, send_data_d;
  logic              data_pid1_q, data_pid1_d;
  logic              in_commit_q, in_commit_d;
  logic              out_commit_q, out_commit_d;
  logic              out_discard_q, out_discard_d;
  logic              sof_q, sof_d;
  logic [NUM_EP-1:0] tgl_q, tgl_d;
  logic              tgl_flip, tgl_set;

  logic [EpSpace-1:0] en_x, stall_x, rdy_x, space_x, tgl_x;

  assign en_x    = EpSpace'(ep_en);
  assign stall_x = EpSpace'(ep_stall);
  assign rdy_x   = EpSpace'(ep_in_rdy);
  assign space_x = EpSpace'(ep_out_space);
  assign tgl_x   = EpSpace'(tgl_q);

  logic tok_ok, addr_ok, ep_req, data_ok, tmo_expired, tmo_load, tmo_en;

  assign tok_ok  = bus.token_valid & ~bus.crc5_err & ~bus.pid_cks_err;
  assign addr_ok = (bus.token_fadr == cfg_fadr) && (32'(bus.token_endp) < NUM_EP) &&
                   en_x[bus.token_endp];
  assign ep_req  = tok_ok & addr_ok & (bus.pid_OUT | bus.pid_IN | bus.pid_SETUP);
  assign data_ok = ~bus.crc16_err & (bus.pid_DATA0 | bus.pid_DATA1);

  // Reload on every state change so each wait starts from a full TMO_CYC window.
  assign tmo_load = (state_d != state_q);
  assign tmo_en   = (state_q == StRxData) || (state_q == StWaitAck);

  usb1bd_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ep_req) begin
          if (bus.pid_IN) begin
            state_d = (stall_x[bus.token_endp] || !rdy_x[bus.token_endp]) ? StTxHs : StTxData;
          end else begin
            state_d = StRxData;
          end
        end
      end
      StRxData: begin
        if (bus.rx_data_done) begin
          state_d = data_ok ? StTxHs : StIdle;
        end else if (tmo_expired) begin
          state_d = StIdle;
        end
      end
      StTxHs: begin
        if (bus.tx_done) state_d = StIdle;
      end
      StTxData: begin
        if (bus.tx_done) state_d = StWaitAck;
      end
      StWaitAck: begin
        if (bus.token_valid || tmo_expired) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ep_sel_d      = ep_sel_q;
    setup_d       = setup_q;
    space_d       = space_q;
    send_hs_d     = 1'b0;
    hs_code_d     = hs_code_q;
    send_data_d   = 1'b0;
    data_pid1_d   = data_pid1_q;
    in_commit_d   = 1'b0;
    out_commit_d  = 1'b0;
    out_discard_d = 1'b0;
    sof_d         = 1'b0;
    tgl_flip      = 1'b0;
    tgl_set       = 1'b0;
    unique case (state_q)
      StIdle: begin
        sof_d = tok_ok & bus.pid_SOF;
        if (ep_req) begin
          ep_sel_d = bus.token_endp;
          setup_d  = bus.pid_SETUP;
          space_d  = space_x[bus.token_endp];
          if (bus.pid_IN) begin
            if (stall_x[bus.token_endp]) begin
              send_hs_d = 1'b1;
              hs_code_d = HS_STALL;
            end else if (!rdy_x[bus.token_endp]) begin
              send_hs_d = 1'b1;
              hs_code_d = HS_NAK;
            end else begin
              send_data_d = 1'b1;
              data_pid1_d = tgl_x[bus.token_endp];
            end
          end
        end
      end
      StRxData: begin
        if (bus.rx_data_done) begin
          if (!data_ok) begin
            out_discard_d = 1'b1;
          end else begin
            send_hs_d = 1'b1;
            hs_code_d = HS_ACK;
            if (setup_q) begin
              // SETUP is always ACKed, even on a halted endpoint.
              if (bus.pid_DATA0) begin
                out_commit_d = 1'b1;
                tgl_set      = 1'b1;
              end else begin
                out_discard_d = 1'b1;
              end
            end else if (stall_x[ep_sel_q]) begin
              hs_code_d     = HS_STALL;
              out_discard_d = 1'b1;
            end else if (!space_q) begin
              hs_code_d     = HS_NAK;
              out_discard_d = 1'b1;
            end else if (bus.pid_DATA1 != tgl_x[ep_sel_q]) begin
              out_discard_d = 1'b1;
            end else begin
              out_commit_d = 1'b1;
              tgl_flip     = 1'b1;
            end
          end
        end
      end
      StWaitAck: begin
        if (bus.token_valid && bus.pid_ACK && !bus.pid_cks_err) begin
          in_commit_d = 1'b1;
          tgl_flip    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A clear pulse wins over a same-cycle flip or set on that endpoint.
  always_comb begin
    tgl_d = tgl_q;
    for (int i = 0; i < NUM_EP; i++) begin
      if (ep_tgl_clr[i]) begin
        tgl_d[i] = 1'b0;
      end else if (ep_sel_q == 4'(i)) begin
        if (tgl_flip) begin
          tgl_d[i] = ~tgl_q[i];
        end else if (tgl_set) begin
          tgl_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ep_sel_q      <= '0;
      setup_q       <= 1'b0;
      space_q       <= 1'b0;
      send_hs_q     <= 1'b0;
      hs_code_q     <= HS_ACK;
      send_data_q   <= 1'b0;
      data_pid1_q   <= 1'b0;
      in_commit_q   <= 1'b0;
      out_commit_q  <= 1'b0;
      out_discard_q <= 1'b0;
      sof_q         <= 1'b0;
      tgl_q         <= '0;
    end else begin
      ep_sel_q      <= ep_sel_d;
      setup_q       <= setup_d;
      space_q       <= space_d;
      send_hs_q     <= send_hs_d;
      hs_code_q     <= hs_code_d;
      send_data_q   <= send_data_d;
      data_pid1_q   <= data_pid1_d;
      in_commit_q   <= in_commit_d;
      out_commit_q  <= out_commit_d;
      out_discard_q <= out_discard_d;
      sof_q         <= sof_d;
      tgl_q         <= tgl_d;
    end
  end

  assign bus.ep_sel         = ep_sel_q;
  assign bus.send_hs        = send_hs_q;
  assign bus.hs_code        = hs_code_q;
  assign bus.send_data      = send_data_q;
  assign bus.data_pid1      = data_pid1_q;
  assign bus.ep_in_commit   = in_commit_q;
  assign bus.ep_out_commit  = out_commit_q;
  assign bus.ep_out_discard = out_discard_q;
  assign bus.sof_pulse      = sof_q;
  assign ep_tgl             = tgl_q;

endmodule
